serializer_arbiter: RTL

- Round-robin scheduler that shares one serializer datapath among CH requesters.
- Each requester offers a parallel word, a bit count and a valid flag over a valid/ready handshake.
- The arbiter grants one requester, launches the word into the serializer with a single-cycle strobe, and tracks the serializer's busy flag until the transfer completes.
- Malformed requests are rejected so they never reach the serializer.

---
 rtl/serializer_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/serializer_arbiter.sv
// serializer_arbiter: round-robin scheduler sharing one serializer among CH requesters.
// A granted word is launched with a one-cycle strobe, then the arbiter waits out the
// serializer's busy window before arbitrating again. Out-of-range bit counts are dropped.
module serializer_arbiter #(
   parameter int WIDTH = 16,
   parameter int CH    = 4
) (
   input  logic                                clk_i,
   input  logic                                srst_i,
   input  logic [CH-1:0][WIDTH-1:0]            req_data_i,
   input  logic [CH-1:0][$clog2(WIDTH):0]      req_mod_i,
   input  logic [CH-1:0]                       req_val_i,
   output logic [CH-1:0]                       req_ready_o,
   output logic [WIDTH-1:0]                    ser_data_o,
   output logic [$clog2(WIDTH):0]              ser_mod_o,
   output logic                                ser_val_o,
   input  logic                                ser_busy_i,
   output logic [$clog2(CH)-1:0]               grant_id_o,
   output logic                                busy_o,
   output logic                                drop_o
);

   localparam int MOD_W   = $clog2(WIDTH) + 1;
   localparam int ID_W    = $clog2(CH);
   localparam int MIN_MOD = 4;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LAUNCH    = 2'd1,
      S_GUARD     = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [ID_W-1:0]     rr_ptr_q;
   logic                guard_cnt_q;
   logic [WIDTH-1:0]    data_q;
   logic [MOD_W-1:0]    mod_q;
   logic [ID_W-1:0]     grant_q;
   logic                drop_q;

   logic                win_found;
   logic [ID_W-1:0]     win_idx;
   logic [MOD_W-1:0]    win_mod;
   logic                mod_ok;
   logic                accept;

   // Channel index ptr+off folded back into 0..CH-1 (off is always below CH).
   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] ptr, input int off);
      int s;
      s = int'(ptr) + off;
      if (s >= CH) s = s - CH;
      return ID_W'(s);
   endfunction

   // A bit count is serviceable only inside MIN_MOD..WIDTH.
   function automatic logic mod_valid(input logic [MOD_W-1:0] m);
      return (m >= MOD_W'(MIN_MOD)) && (m <= MOD_W'(WIDTH));
   endfunction

   // Round-robin search: first valid channel starting at the pointer, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 0; i < CH; i++) begin
         if (!win_found && req_val_i[wrap_add(rr_ptr_q, i)]) begin
            win_found = 1'b1;
            win_idx   = wrap_add(rr_ptr_q, i);
         end
      end
   end

   // Handshake fires only in IDLE with the serializer quiet; reset suppresses it.
   always_comb begin
      win_mod = req_mod_i[win_idx];
      mod_ok  = mod_valid(win_mod);
      accept  = (state_q == S_IDLE) && !ser_busy_i && win_found && !srst_i;
   end

   // FSM state register and guard counter.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q     <= S_IDLE;
         guard_cnt_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         guard_cnt_q <= (state_q == S_GUARD) ? ~guard_cnt_q : 1'b0;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept && mod_ok) state_d = S_LAUNCH;
         end
         S_LAUNCH: begin
            state_d = S_GUARD;
         end
         S_GUARD: begin
            // Busy from the serializer lags the strobe by two cycles; ignore it here.
            if (guard_cnt_q) state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (!ser_busy_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: one-hot ready for the winner, launch strobe, busy flag.
   always_comb begin
      req_ready_o = '0;
      if (accept) req_ready_o[win_idx] = 1'b1;
      ser_val_o = (state_q == S_LAUNCH);
      busy_o    = (state_q != S_IDLE);
   end

   // Latch the accepted request, advance the pointer, flag rejected requests.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         rr_ptr_q <= '0;
         data_q   <= '0;
         mod_q    <= '0;
         grant_q  <= '0;
         drop_q   <= 1'b0;
      end else begin
         drop_q <= accept && !mod_ok;
         if (accept) begin
            data_q   <= req_data_i[win_idx];
            mod_q    <= win_mod;
            grant_q  <= win_idx;
            rr_ptr_q <= wrap_add(win_idx, 1);
         end
      end
   end

   assign ser_data_o = data_q;
   assign ser_mod_o  = mod_q;
   assign grant_id_o = grant_q;
   assign drop_o     = drop_q;

endmodule
